// File: rtl/encoder8to3_scan.sv
// encoder8to3_scan
// ----------------
// Sequential 8-to-3 encoder. Accepts a multi-hot request vector over a
// valid/ready handshake and emits the 3-bit index of every set bit, one
// index per output beat, over a second valid/ready handshake. The final
// beat of each vector is flagged with out_last.
//
// Build option:
//   ENC_HIGH_FIRST_EN  defined     -> bits are emitted highest index first
//                      not defined -> bits are emitted lowest index first
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low
//   in_valid   in_req is valid
//   in_ready   block can accept a vector (registered)
//   in_req     request vector, bit i maps to code i
//   out_valid  out_code is valid (registered)
//   out_ready  downstream accepts the beat
//   out_code   index of the current set bit (registered)
//   out_last   current beat is the last set bit of the vector (registered)
//   busy       a vector is being emitted (registered)
//   empty_err  one-cycle pulse after an all-zero vector is accepted
module encoder8to3_scan (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_req,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_code,
  output logic       out_last,
  output logic       busy,
  output logic       empty_err
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t     state_reg, state_next;
  logic [7:0] pending_reg, pending_next;
  logic       in_ready_reg, in_ready_next;
  logic       out_valid_reg, out_valid_next;
  logic [2:0] out_code_reg, out_code_next;
  logic       out_last_reg, out_last_next;
  logic       busy_reg, busy_next;
  logic       empty_err_reg, empty_err_next;

  logic       in_hs;
  logic       out_hs;
  logic [7:0] code_onehot;
  logic [7:0] remaining;

  // Index of the set bit to emit next; the later assignment in the loop
  // wins, so the loop direction selects the scan order.
  function automatic logic [2:0] pick(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
`ifdef ENC_HIGH_FIRST_EN
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
`else
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
`endif
    return idx;
  endfunction

  function automatic logic single_bit(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  assign in_hs  = in_valid & in_ready_reg;
  assign out_hs = out_valid_reg & out_ready;

  // Decode the current code back to one-hot to clear the emitted bit.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_onehot
      assign code_onehot[gi] = (out_code_reg == 3'(gi));
    end
  endgenerate

  assign remaining = pending_reg & ~code_onehot;

  // State register plus the registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      pending_reg   <= 8'd0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_code_reg  <= 3'd0;
      out_last_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      empty_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pending_reg   <= pending_next;
      in_ready_reg  <= in_ready_next;
      out_valid_reg <= out_valid_next;
      out_code_reg  <= out_code_next;
      out_last_reg  <= out_last_next;
      busy_reg      <= busy_next;
      empty_err_reg <= empty_err_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_hs && (in_req != 8'd0)) state_next = EMIT;
      EMIT: if (out_hs && out_last_reg)    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: values loaded into the output registers. Handshake flags
  // follow the next state so they change on the same edge as the FSM.
  always_comb begin
    pending_next   = pending_reg;
    out_code_next  = out_code_reg;
    out_last_next  = out_last_reg;
    empty_err_next = 1'b0;
    in_ready_next  = (state_next == IDLE);
    out_valid_next = (state_next == EMIT);
    busy_next      = (state_next == EMIT);
    case (state_reg)
      IDLE: begin
        if (in_hs) begin
          if (in_req == 8'd0) begin
            empty_err_next = 1'b1;
          end else begin
            pending_next  = in_req;
            out_code_next = pick(in_req);
            out_last_next = single_bit(in_req);
          end
        end
      end
      EMIT: begin
        if (out_hs) begin
          pending_next = remaining;
          if (out_last_reg) begin
            out_last_next = 1'b0;
          end else begin
            out_code_next = pick(remaining);
            out_last_next = single_bit(remaining);
          end
        end
      end
      default: ;
    endcase
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_code  = out_code_reg;
  assign out_last  = out_last_reg;
  assign busy      = busy_reg;
  assign empty_err = empty_err_reg;

endmodule

// File: tb/tb_encoder8to3_scan.sv
// Testbench for encoder8to3_scan: directed steps followed by random vectors
// with random backpressure, checked against a queue-based model of the
// expected code sequence. Honours ENC_HIGH_FIRST_EN for the scan order.
module tb_encoder8to3_scan;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_req;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_code;
  logic       out_last;
  logic       busy;
  logic       empty_err;

  int checks = 0;
  int errors = 0;

  encoder8to3_scan dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_req    (in_req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_last  (out_last),
    .busy      (busy),
    .empty_err (empty_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge with the block idle. Sends vector v, then
  // drains it. out_ready follows pat[0..pat_len-1] first, then random (rnd)
  // or constant 1. If abort_after >= 0, reset is applied once that many
  // beats have been accepted.
  task automatic run_vec(input logic [7:0] v, input logic [15:0] pat,
                         input int pat_len, input bit rnd, input int abort_after);
    int q[$];
    int guard;
    int step;
    int beats;
    logic r;
    // Model: indices of set bits in scan order.
`ifdef ENC_HIGH_FIRST_EN
    for (int i = 7; i >= 0; i--) if (((v >> i) & 8'd1) != 8'd0) q.push_back(i);
`else
    for (int i = 0; i < 8; i++) if (((v >> i) & 8'd1) != 8'd0) q.push_back(i);
`endif
    guard = 0;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_wait", 32'(guard < 20), 32'd1);
    in_valid = 1'b1;
    in_req   = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    if (v == 8'd0) begin
      chk("zero_err", empty_err, 1'b1);
      chk("zero_valid", out_valid, 1'b0);
      chk("zero_ready", in_ready, 1'b1);
      @(negedge clk);
      chk("zero_err_clear", empty_err, 1'b0);
      $display("vec %02h beats 0 empty", v);
      return;
    end
    step  = 0;
    beats = 0;
    while (q.size() > 0 && step < 300) begin
      chk("emit_valid", out_valid, 1'b1);
      chk("emit_busy", busy, 1'b1);
      chk("emit_in_ready", in_ready, 1'b0);
      chk("emit_code", out_code, q[0]);
      chk("emit_last", out_last, 32'(q.size() == 1));
      chk("emit_err", empty_err, 1'b0);
      if (abort_after >= 0 && beats == abort_after) begin
        rst_n     = 1'b0;
        out_ready = 1'($urandom);
        @(posedge clk);
        @(negedge clk);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_code", out_code, 3'd0);
        chk("rst_last", out_last, 1'b0);
        chk("rst_err", empty_err, 1'b0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_release_ready", in_ready, 1'b1);
        chk("rst_release_valid", out_valid, 1'b0);
        $display("vec %02h aborted after %0d beats", v, beats);
        return;
      end
      if (step < pat_len) r = pat[step];
      else if (rnd)       r = 1'($urandom);
      else                r = 1'b1;
      step++;
      out_ready = r;
      // Inputs during emission must be ignored.
      in_valid = 1'($urandom);
      in_req   = 8'($urandom);
      @(posedge clk);
      if (r) begin
        void'(q.pop_front());
        beats++;
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("drain_done", 32'(q.size()), 32'd0);
    chk("done_valid", out_valid, 1'b0);
    chk("done_in_ready", in_ready, 1'b1);
    chk("done_busy", busy, 1'b0);
    $display("vec %02h beats %0d cycles %0d", v, beats, step);
  endtask

  initial begin
    logic [7:0] v;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_req    = 8'd0;
    out_ready = 1'b0;

    // Reset held for two cycles.
    @(negedge clk);
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1'b0);
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_err", empty_err, 1'b0);
    chk("reset_code", out_code, 3'd0);
    chk("reset_last", out_last, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1'b1);
    chk("idle_valid", out_valid, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_err", empty_err, 1'b0);

    // Single bit.
    run_vec(8'h20, 16'h0, 0, 1'b0, -1);
    // Multi-bit with backpressure 1,0,1,1,0,1.
    run_vec(8'hA5, 16'b101101, 6, 1'b0, -1);

    // Back-to-back zero vectors.
    in_valid = 1'b1;
    in_req   = 8'h00;
    @(negedge clk);
    chk("zero1_err", empty_err, 1'b1);
    chk("zero1_valid", out_valid, 1'b0);
    chk("zero1_ready", in_ready, 1'b1);
    @(negedge clk);
    chk("zero2_err", empty_err, 1'b1);
    chk("zero2_valid", out_valid, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("zero_err_end", empty_err, 1'b0);
    $display("vec 00 x2 back-to-back");

    // Reset after the third beat of 8'hFF, then a fresh vector.
    run_vec(8'hFF, 16'h0, 0, 1'b0, 3);
    run_vec(8'h02, 16'h0, 0, 1'b0, -1);
    run_vec(8'h81, 16'h0, 0, 1'b0, -1);
    run_vec(8'hFF, 16'h0, 0, 1'b0, -1);
    run_vec(8'h80, 16'h0, 0, 1'b0, -1);
    run_vec(8'h01, 16'h0, 0, 1'b0, -1);

    // Random vectors with random backpressure.
    for (int n = 0; n < 60; n++) begin
      v = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      run_vec(v, 16'h0, 0, 1'b1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
